// File: rtl/div_unit_if.sv
// Execute-stage divider handshake: operands and start from the pipeline,
// busy/ready/result back from the divider.
interface div_unit_if;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        busy;
    logic        ready;
    logic [63:0] result;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  busy, ready, result
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output busy, ready, result
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider (DIV/DIVU), one quotient bit per cycle,
// returning {remainder, quotient} with a single-cycle ready pulse.
module div_unit (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  dif
);

    typedef enum logic [1:0] {IDLE, DIV0, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [31:0] dvsr;
    logic        sign_q, sign_r;
    logic [63:0] result_q;

    logic [31:0] abs1, abs2;
    logic [64:0] work_sh, work_nx;
    logic [32:0] diff;
    logic [31:0] q_fin, r_fin;
    logic        accept;

    always_comb begin
        abs1    = (dif.signed_div & dif.opdata1[31]) ? -dif.opdata1 : dif.opdata1;
        abs2    = (dif.signed_div & dif.opdata2[31]) ? -dif.opdata2 : dif.opdata2;
        accept  = dif.start & ~dif.annul;
        work_sh = work << 1;
        diff    = work_sh[64:32] - {1'b0, dvsr};
        work_nx = diff[32] ? work_sh : {diff, work_sh[31:1], 1'b1};
        q_fin   = sign_q ? -work_nx[31:0]  : work_nx[31:0];
        r_fin   = sign_r ? -work_nx[63:32] : work_nx[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        dif.busy  = 1'b0;
        dif.ready = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nx = (dif.opdata2 == '0) ? DIV0 : BUSY;
            end
            DIV0: begin
                state_nx = dif.annul ? IDLE : DONE;
            end
            BUSY: begin
                dif.busy = 1'b1;
                if (dif.annul)           state_nx = IDLE;
                else if (cnt == 6'd31)   state_nx = DONE;
            end
            DONE: begin
                dif.ready = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The signed fix-up is applied to the final step's output so the result
    // register is already valid during the DONE cycle when ready is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            work     <= '0;
            dvsr     <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && dif.opdata2 != '0) begin
                        dvsr   <= abs2;
                        sign_q <= dif.signed_div & (dif.opdata1[31] ^ dif.opdata2[31]);
                        sign_r <= dif.signed_div & dif.opdata1[31];
                        work   <= {33'b0, abs1};
                        cnt    <= '0;
                    end
                end
                DIV0: begin
                    if (!dif.annul) result_q <= '0;
                end
                BUSY: begin
                    if (!dif.annul) begin
                        work <= work_nx;
                        cnt  <= cnt + 6'd1;
                        if (cnt == 6'd31) result_q <= {r_fin, q_fin};
                    end
                end
                default: ;
            endcase
        end
    end

    assign dif.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected results and ready
// cycles, a negedge monitor pops and compares on every ready pulse.
module tb_div_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if dif();
    div_unit dut (.clk(clk), .rst(rst), .dif(dif));

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_exp(input logic [63:0] res, input int at);
        exp_t e;
        e.res = res;
        e.cyc = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && dif.ready === 1'b1) begin
            exp_t e;
            check("busy_during_ready", 64'(dif.busy), 64'd0);
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_ready: got ready with empty scoreboard, expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("result", dif.result, e.res);
                check("ready_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Issue one op at the current negedge, wait for ready, end one cycle later in IDLE.
    task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input int exp_busy,
                          input bit pulse);
        int nb = 0;
        int n = 0;
        bit done = 0;
        dif.signed_div = sd;
        dif.opdata1    = a;
        dif.opdata2    = b;
        dif.start      = 1'b1;
        push_exp(exp, cyc + lat);
        while (!done && n < 80) begin
            @(negedge clk);
            n++;
            if (n == 1) dif.start = 1'b0;
            if (pulse && n == 10) dif.start = 1'b1;
            if (pulse && n == 11) dif.start = 1'b0;
            if (dif.busy === 1'b1) nb++;
            if (dif.ready === 1'b1) done = 1;
        end
        dif.start = 1'b0;
        check("busy_cycles", 64'(nb), 64'(exp_busy));
        if (!done) begin
            total++;
            $display("FAIL op_timeout: got no ready after %0d cycles, expected ready", n);
        end
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dif.ready !== 1'b1 && n < 80);
        if (dif.ready !== 1'b1) begin
            total++;
            $display("FAIL b2b_timeout: got no ready after %0d cycles, expected ready", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int r1;
        dif.start      = 1'b0;
        dif.annul      = 1'b0;
        dif.signed_div = 1'b0;
        dif.opdata1    = '0;
        dif.opdata2    = '0;
        rst            = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy",   64'(dif.busy),  64'd0);
        check("reset_ready",  64'(dif.ready), 64'd0);
        check("reset_result", dif.result,     64'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        33, 32, 1'b0);
        run_op(1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  33, 32, 1'b0);
        run_op(1'b1, 32'd7,          32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD},  33, 32, 1'b0);
        run_op(1'b1, 32'hFFFFFF9C,   32'd7,        {32'hFFFFFFFE, 32'hFFFFFFF2},  33, 32, 1'b0);
        run_op(1'b0, 32'hFFFFFFF9,   32'd2,        {32'd1,        32'h7FFFFFFC},  33, 32, 1'b0);
        run_op(1'b1, 32'h80000000,   32'hFFFFFFFF, {32'd0,        32'h80000000},  33, 32, 1'b0);
        run_op(1'b0, 32'hFFFFFFFF,   32'd1,        {32'd0,        32'hFFFFFFFF},  33, 32, 1'b0);
        run_op(1'b0, 32'd5,          32'd9,        {32'd5,        32'd0},         33, 32, 1'b1);

        // annul ten cycles into a division; no pulse, result keeps {5,0}
        dif.signed_div = 1'b0;
        dif.opdata1    = 32'd1000;
        dif.opdata2    = 32'd3;
        dif.start      = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (9) @(negedge clk);
        dif.annul = 1'b1;
        @(negedge clk);
        dif.annul = 1'b0;
        check("annul_busy",   64'(dif.busy),  64'd0);
        check("annul_ready",  64'(dif.ready), 64'd0);
        check("annul_result", dif.result,     {32'd5, 32'd0});
        run_op(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33, 32, 1'b0);

        // reset mid-division
        dif.opdata1 = 32'd77;
        dif.opdata2 = 32'd3;
        dif.start   = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy",   64'(dif.busy),  64'd0);
        check("midrst_ready",  64'(dif.ready), 64'd0);
        check("midrst_result", dif.result,     64'h0);
        rst = 1'b0;
        @(negedge clk);

        // back-to-back with start held until each ready
        dif.signed_div = 1'b0;
        dif.opdata1    = 32'd50;
        dif.opdata2    = 32'd5;
        dif.start      = 1'b1;
        push_exp({32'd0, 32'd10}, cyc + 33);
        wait_ready(n);
        r1 = cyc;
        dif.opdata1 = 32'd77;
        dif.opdata2 = 32'd10;
        push_exp({32'd7, 32'd7}, r1 + 34);
        wait_ready(n);
        dif.start = 1'b0;
        @(negedge clk);

        run_op(1'b0, 32'd123, 32'd0, 64'h0, 2, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
